// File: rtl/note_frame_gen.sv
// note_frame_gen
// Video timing source that paints five note boxes (lane 0 green .. lane 4
// orange) over a background. It drives a closed-loop stimulus into the
// fret-detection pipeline. Note masks are double-buffered, so the visible
// mask changes only on frame boundaries.
//
// Ports
//   CLK         pixel clock
//   RST         synchronous active-high reset
//   Enable      1: draw boxes, 0: active area shows Background only
//   LanePos     lane i at [24i+23:24i]: x = [10:0], y = [21:12]
//   LaneOn      lane i on-colour at [24i+23:24i]
//   OffColour   box colour when the lane's note bit is clear
//   Background  active-area colour outside the boxes
//   NoteMask    requested note state, bit i = lane i
//   NoteLoad    strobe that captures NoteMask into the pending mask
//   HSync       horizontal sync, active-high
//   VSync       vertical sync, active-high, whole-line aligned
//   VDE         active video
//   RGB         pixel colour, 0 outside active video
//   FrameStart  one-cycle pulse with pixel (0,0)
//   FrameCount  completed-frame counter, wraps modulo 2^16
//
// Every output is registered from the counters of the previous cycle, so
// all outputs share a fixed one-cycle latency.
module note_frame_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BOX      = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Enable,
  input  logic [119:0] LanePos,
  input  logic [119:0] LaneOn,
  input  logic [23:0]  OffColour,
  input  logic [23:0]  Background,
  input  logic [4:0]   NoteMask,
  input  logic         NoteLoad,
  output logic         HSync,
  output logic         VSync,
  output logic         VDE,
  output logic [23:0]  RGB,
  output logic         FrameStart,
  output logic [15:0]  FrameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_MAX    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_MAX    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] BOX_M1   = 12'(BOX - 1);

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic        h_wrap, v_wrap, frame_wrap;

  logic [4:0]  pend_mask_q, pend_mask_d;
  logic [4:0]  act_mask_q, act_mask_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        hsync_d, vsync_d, vde_d, fstart_d;
  logic [23:0] rgb_d;
  logic        hsync_q, vsync_q, vde_q, fstart_q;
  logic [23:0] rgb_q;

  logic [11:0] lane_x [5];
  logic [11:0] lane_y [5];
  logic [4:0]  hit;

  // Bits 11, 22 and 23 of each lane position field carry nothing.
  logic unused_lane_pos_bits;
  assign unused_lane_pos_bits = ^{LanePos[119:118], LanePos[107],
                                  LanePos[95:94],   LanePos[83],
                                  LanePos[71:70],   LanePos[59],
                                  LanePos[47:46],   LanePos[35],
                                  LanePos[23:22],   LanePos[11]};

  // Raster counters
  assign h_wrap     = (hcnt_q == H_MAX);
  assign v_wrap     = (vcnt_q == V_MAX);
  assign frame_wrap = h_wrap && v_wrap;

  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = v_wrap ? 12'd0 : vcnt_q + 12'd1;
    end
  end

  // Mask buffering: the active mask takes the pending value held before the
  // wrap edge, so a load on the wrap cycle itself lands one frame later.
  always_comb begin
    pend_mask_d = NoteLoad ? NoteMask : pend_mask_q;
    act_mask_d  = frame_wrap ? pend_mask_q : act_mask_q;
    frame_cnt_d = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Box hit test in 12-bit arithmetic so that x+BOX-1 cannot wrap.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      lane_x[i] = {1'b0, LanePos[24*i +: 11]};
      lane_y[i] = {2'b00, LanePos[24*i+12 +: 10]};
      hit[i]    = (hcnt_q >= lane_x[i]) && (hcnt_q <= lane_x[i] + BOX_M1) &&
                  (vcnt_q >= lane_y[i]) && (vcnt_q <= lane_y[i] + BOX_M1);
    end
  end

  // Timing decode and colour selection for the current counter values
  always_comb begin
    hsync_d  = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
    vsync_d  = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
    vde_d    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    fstart_d = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);

    rgb_d = Background;
    // Walk from the highest lane down so the lowest hitting lane wins.
    for (int i = 4; i >= 0; i--) begin
      if (hit[i]) begin
        rgb_d = act_mask_q[i] ? LaneOn[24*i +: 24] : OffColour;
      end
    end
    if (!Enable) begin
      rgb_d = Background;
    end
    if (!vde_d) begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      pend_mask_q <= '0;
      act_mask_q  <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      vde_q       <= 1'b0;
      fstart_q    <= 1'b0;
      rgb_q       <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      pend_mask_q <= pend_mask_d;
      act_mask_q  <= act_mask_d;
      frame_cnt_q <= frame_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      vde_q       <= vde_d;
      fstart_q    <= fstart_d;
      rgb_q       <= rgb_d;
    end
  end

  assign HSync      = hsync_q;
  assign VSync      = vsync_q;
  assign VDE        = vde_q;
  assign RGB        = rgb_q;
  assign FrameStart = fstart_q;
  assign FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_note_frame_gen.sv
// Directed bench for note_frame_gen using a reduced raster:
// H 8/2/2/2 (14 cycles per line), V 4/1/1/1 (7 lines), 98 cycles per frame,
// BOX = 2. Lane 0 sits at (2,1); lanes 1 and 3 share (5,2); lanes 2 and 4
// are parked off-screen at (100,100).
module tb_note_frame_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [119:0] lane_pos;
  logic [119:0] lane_on;
  logic [23:0]  off_colour;
  logic [23:0]  background;
  logic [4:0]   note_mask;
  logic         note_load;
  logic         hsync, vsync, vde, frame_start;
  logic [23:0]  rgb;
  logic [15:0]  frame_count;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] BG  = 24'h123456;
  localparam logic [23:0] OFF = 24'h00AA00;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] GRN = 24'h00FF00;

  note_frame_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BOX(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .Enable(enable),
    .LanePos(lane_pos),
    .LaneOn(lane_on),
    .OffColour(off_colour),
    .Background(background),
    .NoteMask(note_mask),
    .NoteLoad(note_load),
    .HSync(hsync),
    .VSync(vsync),
    .VDE(vde),
    .RGB(rgb),
    .FrameStart(frame_start),
    .FrameCount(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hand-placed expectation: lane 0 box covers x 2..3, y 1..2; lanes 1/3
  // box covers x 5..6, y 2..3 and lane 1 has priority there.
  function automatic logic [23:0] exp_rgb(input int h, input int v,
                                          input bit en, input logic [4:0] m);
    if (!(h < 8 && v < 4)) return 24'h0;
    if (!en) return BG;
    if ((h == 2 || h == 3) && (v == 1 || v == 2)) return m[0] ? RED : OFF;
    if ((h == 5 || h == 6) && (v == 2 || v == 3)) return m[1] ? BLU : OFF;
    return BG;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd0);
    chk({tag, "_vsync"}, 32'(vsync), 32'd0);
    chk({tag, "_vde"},   32'(vde),   32'd0);
    chk({tag, "_rgb"},   32'(rgb),   32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_fc"},    32'(frame_count), 32'd0);
  endtask

  // Called with the counters at pixel 0 of a frame. Iteration k drives the
  // cycle whose counters equal k, then checks the output for pixel k.
  task automatic run_frame(input int fc, input bit en, input logic [4:0] m,
                           input int load_at, input logic [4:0] load_val);
    int h, v;
    enable = en;
    for (int k = 0; k < 98; k++) begin
      note_load = (k == load_at);
      note_mask = load_val;
      step();
      h = k % 14;
      v = k / 14;
      chk($sformatf("vde_f%0d_%0d_%0d", fc, h, v), 32'(vde), 32'(h < 8 && v < 4));
      chk($sformatf("hs_f%0d_%0d_%0d", fc, h, v), 32'(hsync), 32'(h == 10 || h == 11));
      chk($sformatf("vs_f%0d_%0d_%0d", fc, h, v), 32'(vsync), 32'(v == 5));
      chk($sformatf("fs_f%0d_%0d_%0d", fc, h, v), 32'(frame_start), 32'(k == 0));
      chk($sformatf("rgb_f%0d_%0d_%0d", fc, h, v), 32'(rgb), 32'(exp_rgb(h, v, en, m)));
      chk($sformatf("fc_f%0d_%0d_%0d", fc, h, v), 32'(frame_count),
          32'((k == 97) ? fc + 1 : fc));
    end
    note_load = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    lane_pos   = {24'h064064, 24'h002005, 24'h064064, 24'h002005, 24'h001002};
    lane_on    = {24'hFFFFFF, GRN, 24'hABCDEF, BLU, RED};
    off_colour = OFF;
    background = BG;
    note_mask  = '0;
    note_load  = 1'b0;

    repeat (3) step();
    all_zero("reset");

    rst = 1'b0;
    all_zero("first_cycle");

    // Frame 0: timing only, boxes disabled.
    run_frame(0, 1'b0, 5'b00000, -1, 5'b00000);
    // Frame 1: boxes drawn with the reset mask; a mid-frame load is pending.
    run_frame(1, 1'b1, 5'b00000, 40, 5'b01011);
    // Frame 2: loaded mask visible; load on the wrap cycle.
    run_frame(2, 1'b1, 5'b01011, 97, 5'b00010);
    // Frame 3: wrap-cycle load not yet visible.
    run_frame(3, 1'b1, 5'b01011, -1, 5'b00000);
    // Frame 4: wrap-cycle load visible, lane 0 now off.
    run_frame(4, 1'b1, 5'b00010, -1, 5'b00000);

    // Reset in the middle of line 2.
    repeat (30) step();
    rst = 1'b1;
    step();
    all_zero("mid_reset");
    step();
    rst = 1'b0;
    all_zero("post_release");
    run_frame(0, 1'b1, 5'b00000, -1, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
